// File: rtl/sram_responder.sv
// sram_responder: cycle-based 16-bit async SRAM with programmable read latency, counters, backdoor preload; `SRAM_RESPONDER_RANGE_CHECK_EN adds out-of-range checking
module sram_responder #(
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [17:0]           addr,
  inout  wire  [15:0]           data,
  input  logic                  wre,
  input  logic                  oute,
  input  logic                  hb_mask,
  input  logic                  lb_mask,
  input  logic                  chip_en,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [15:0]           load_data,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic                  contention,
  output logic                  out_of_range
);
  logic [15:0]           r_mem [2**DEPTH_LOG2];
  logic [READ_LATENCY-1:0] r_vld;
  logic [15:0]           r_dat [READ_LATENCY];
  logic [1:0]            r_be  [READ_LATENCY];
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;
  logic                  r_contention;
  logic                  w_sel;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_oor;
  logic                  w_wen;
  logic                  w_out;
  logic                  w_drv;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_be;
  logic [15:0]           w_rword;
  logic [15:0]           w_odat;
  logic [1:0]            w_obe;

  assign w_sel   = !chip_en && !load_en && !reset;
  assign w_wr    = w_sel && !wre;
  assign w_rd    = w_sel && wre && !oute;
  assign w_idx   = addr[DEPTH_LOG2-1:0];
  assign w_be    = {hb_mask, lb_mask};
  assign w_wen   = w_wr && !w_oor && !(&w_be);
  assign w_rword = w_oor ? 16'hDEAD : r_mem[w_idx];
  assign w_out   = r_vld[READ_LATENCY-1];
  assign w_odat  = r_dat[READ_LATENCY-1];
  assign w_obe   = r_be[READ_LATENCY-1];
  assign w_drv   = w_out && !chip_en && !oute && wre;
  assign data    = {(w_drv && !w_obe[1]) ? w_odat[15:8] : 8'hzz,
                    (w_drv && !w_obe[0]) ? w_odat[7:0]  : 8'hzz};
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;
  assign contention = r_contention;

`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
  logic r_oor;
  assign w_oor        = |addr[17:DEPTH_LOG2];
  assign out_of_range = r_oor;
  // sticky flag for any bus access touching addresses beyond the array
  always_ff @(posedge clock) begin
    if (reset) r_oor <= 1'b0;
    else if ((w_wr || w_rd) && w_oor) r_oor <= 1'b1;
  end
`else
  logic w_unused_hi;
  assign w_oor        = 1'b0;
  assign out_of_range = 1'b0;
  assign w_unused_hi  = ^addr[17:DEPTH_LOG2];
`endif

  // array update: backdoor has priority over the bus; no reset so contents survive it
  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_addr] <= load_data;
    else if (w_wr && !w_oor) begin
      if (!hb_mask) r_mem[w_idx][15:8] <= data[15:8];
      if (!lb_mask) r_mem[w_idx][7:0]  <= data[7:0];
    end
  end

  // read pipeline: word and byte enables snapshotted at launch, shifted toward the output stage
  always_ff @(posedge clock) begin
    r_vld[0] <= w_rd;
    r_dat[0] <= w_rword;
    r_be[0]  <= w_be;
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_vld[i] <= r_vld[i-1];
      r_dat[i] <= r_dat[i-1];
      r_be[i]  <= r_be[i-1];
    end
    if (reset) r_vld <= '0;
  end

  // saturating access counters and sticky contention flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_count   <= '0;
      r_wr_count   <= '0;
      r_contention <= 1'b0;
    end else begin
      if (w_rd && !(&r_rd_count)) r_rd_count <= r_rd_count + 16'd1;
      if (w_wen && !(&r_wr_count)) r_wr_count <= r_wr_count + 16'd1;
      if (w_out && !wre) r_contention <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed plus randomized checks of sram_responder against a queue-based reference model
module tb_sram_responder;
  localparam int DL  = 12;
  localparam int LAT = 3;
`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [17:0]   addr = '0;
  tri1  [15:0]   data;
  logic          wre = 1'b1, oute = 1'b1, hb_mask = 1'b0, lb_mask = 1'b0, chip_en = 1'b1, load_en = 1'b0;
  logic [DL-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic [15:0]   rd_count, wr_count;
  logic          contention, out_of_range;
  logic          tb_drv = 1'b0;
  logic [15:0]   tb_wdata = '0;

  assign data = tb_drv ? tb_wdata : 16'hzzzz;
  always #5 clock = ~clock;

  sram_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data), .wre(wre), .oute(oute),
    .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .rd_count(rd_count), .wr_count(wr_count),
    .contention(contention), .out_of_range(out_of_range)
  );

  typedef struct {int due; logic [15:0] w; logic [1:0] be;} rd_t;
  logic [15:0] m_mem [2**DL];
  rd_t         q[$];
  int          n = 0, t = 0, n_tests = 0, n_fail = 0;
  logic [15:0] m_rd = '0, m_wr = '0;
  logic        m_cont = 1'b0, m_oor = 1'b0;
  logic [15:0] obs [8192];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic tick();
    logic [15:0] e, wd;
    logic [DL-1:0] a;
    logic oor;
    #1;
    e = 16'hFFFF;
    if (q.size() != 0 && q[0].due == n && !chip_en && !oute && wre) begin
      if (!q[0].be[1]) e[15:8] = q[0].w[15:8];
      if (!q[0].be[0]) e[7:0]  = q[0].w[7:0];
    end
    obs[t] = data;
    t++;
    if (!tb_drv) chk("data", data, e);
    chk("rd_count", rd_count, m_rd);
    chk("wr_count", wr_count, m_wr);
    chk("contention", {15'd0, contention}, {15'd0, m_cont});
    chk("out_of_range", {15'd0, out_of_range}, {15'd0, m_oor});
    @(posedge clock);
    if (q.size() != 0 && q[0].due == n && !wre) m_cont = 1'b1;
    while (q.size() != 0 && q[0].due <= n) void'(q.pop_front());
    n++;
    a   = addr[DL-1:0];
    oor = RC && (addr >= 18'(2**DL));
    wd  = tb_drv ? tb_wdata : 16'hFFFF;
    if (load_en) m_mem[load_addr] = load_data;
    if (reset) begin
      q.delete();
      m_rd = '0; m_wr = '0; m_cont = 1'b0; m_oor = 1'b0;
    end else if (!load_en && !chip_en) begin
      if (!wre) begin
        if (oor) m_oor = 1'b1;
        else begin
          if (!hb_mask) m_mem[a][15:8] = wd[15:8];
          if (!lb_mask) m_mem[a][7:0]  = wd[7:0];
          if (!(hb_mask && lb_mask)) m_wr = sat(m_wr);
        end
      end else if (!oute) begin
        if (oor) m_oor = 1'b1;
        q.push_back('{n + LAT - 1, oor ? 16'hDEAD : m_mem[a], {hb_mask, lb_mask}});
        m_rd = sat(m_rd);
      end
    end
    @(negedge clock);
  endtask

  task automatic bus(input logic c, w, o, input logic [17:0] a, input logic [15:0] d,
                     input logic hb, lb, drv);
    chip_en = c; wre = w; oute = o; addr = a; tb_wdata = d; tb_drv = drv;
    hb_mask = hb; lb_mask = lb; load_en = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [17:0] a, input logic hb, lb);
    bus(1'b0, 1'b1, 1'b0, a, 16'h0, hb, lb, 1'b0);
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic hb, lb);
    bus(1'b0, 1'b0, 1'b1, a, d, hb, lb, 1'b1);
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b1, 18'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [DL-1:0] a, input logic [15:0] d);
    chip_en = 1'b0; wre = 1'b0; oute = 1'b0; tb_drv = 1'b0; reset = 1'b0;
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic rst_tick();
    chip_en = 1'b0; wre = 1'b1; oute = 1'b0; tb_drv = 1'b0; load_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int s, r;
    logic [17:0] a;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ld(DL'(i), 16'($urandom));
    wr(18'd5, 16'hA5C3, 1'b0, 1'b0);
    s = t; rd(18'd5, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("full_rd", obs[s+LAT], 16'hA5C3);
    repeat (LAT) idle();
    ld(DL'(7), 16'h1234); wr(18'd7, 16'hFFFF, 1'b1, 1'b0);
    s = t; rd(18'd7, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("mask_wr", obs[s+LAT], 16'h12FF);
    ld(DL'(8), 16'h1234);
    s = t; rd(18'd8, 1'b0, 1'b1); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("mask_rd", obs[s+LAT], 16'h12FF);
    repeat (LAT) idle();
    ld(DL'(0), 16'd10); ld(DL'(1), 16'd11); ld(DL'(2), 16'd12);
    s = t; rd(18'd0, 1'b0, 1'b0); rd(18'd1, 1'b0, 1'b0); wr(18'd1, 16'h9999, 1'b0, 1'b0);
    rd(18'd2, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("stream0", obs[s+LAT], 16'd10);
    chk("stream1_old", obs[s+LAT+1], 16'd11);
    chk("stream2", obs[s+LAT+3], 16'd12);
    s = t; rd(18'd1, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("stream1_new", obs[s+LAT], 16'h9999);
    repeat (LAT) idle();
    s = t; rd(18'd5, 1'b0, 1'b0); repeat (LAT-1) idle();
    bus(1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("cont_nodrv", obs[s+LAT], 16'hFFFF);
    chk("cont_set", {15'd0, contention}, 16'd1);
    repeat (5) idle();
    chk("cont_hold", {15'd0, contention}, 16'd1);
    repeat (LAT) idle();
    s = t; rd(18'd5, 1'b0, 1'b0); idle(); rst_tick(); idle();
    chk("rst_nodrv", obs[s+3], 16'hFFFF);
    chk("rst_rdcnt", rd_count, 16'd0);
    chk("rst_cont", {15'd0, contention}, 16'd0);
    s = t; rd(18'd5, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("rst_keep", obs[s+LAT], 16'hA5C3);
    repeat (LAT) idle();
    wr(18'h01005, 16'hBEEF, 1'b0, 1'b0); repeat (LAT) idle();
    s = t; rd(18'd5, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("range_lo", obs[s+LAT], RC ? 16'hA5C3 : 16'hBEEF);
    s = t; rd(18'h01005, 1'b0, 1'b0); repeat (LAT) rd(18'd15, 1'b0, 1'b0);
    chk("range_hi", obs[s+LAT], RC ? 16'hDEAD : 16'hBEEF);
    chk("range_flag", {15'd0, out_of_range}, {15'd0, RC});
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 7) == 0) ? {6'($urandom), 12'($urandom_range(0, 15))}
                                      : 18'($urandom_range(0, 15));
      if (r < 2) rst_tick();
      else if (r < 8) ld(DL'($urandom_range(0, 15)), 16'($urandom));
      else if (r < 38) wr(a, 16'($urandom), 1'($urandom), 1'($urandom));
      else if (r < 78) rd(a, 1'($urandom), 1'($urandom));
      else begin
        logic w;
        w = 1'($urandom);
        bus(1'($urandom), w, 1'($urandom), a, 16'($urandom), 1'($urandom), 1'($urandom), !w);
      end
    end
    repeat (LAT + 2) idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
